// File: rtl/activation.sv
`default_nettype none
// ============================================================================
// Module   : activation
// Brief    : Logistic / clipped-linear activation with a train-mode FIFO of
//            stored activations and a derivative-weighted backward path.
//            Optional macro ACTIVATION_ROUND_EN selects round-half-up scaling.
// Revision : 1.0 - initial release
// ============================================================================
module activation #(
    parameter int ARG_WIDTH = 16,
    parameter int ARG_FRAC  = 8,
    parameter int ACT_WIDTH = 8,
    parameter int ERR_WIDTH = 16,
    parameter int DEPTH     = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 train,
    input  logic                 argument_valid,
    output logic                 argument_ready,
    input  logic [ARG_WIDTH-1:0] argument_data,
    input  logic                 argument_mode,
    output logic                 activation_valid,
    input  logic                 activation_ready,
    output logic [ACT_WIDTH-1:0] activation_data,
    input  logic                 error_valid,
    output logic                 error_ready,
    input  logic [ERR_WIDTH-1:0] error_data,
    output logic                 propagate_valid,
    input  logic                 propagate_ready,
    output logic [ERR_WIDTH-1:0] propagate_data
);

`ifdef ACTIVATION_ROUND_EN
    localparam bit c_ROUND_EN = 1'b1;
`else
    localparam bit c_ROUND_EN = 1'b0;
`endif

    // y is carried with 5 extra fraction bits so |x|/32 is exact
    localparam int c_Y_FRAC = ARG_FRAC + 5;
    localparam int c_YW     = ARG_WIDTH + 7;
    localparam int c_SW     = c_YW + ACT_WIDTH;
    localparam int c_AAW    = 2 * ACT_WIDTH + 1;
    localparam int c_PW     = ERR_WIDTH + ACT_WIDTH + 2;
    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;

    localparam logic [c_YW-1:0]      c_ONE   = c_YW'(1) << c_Y_FRAC;
    localparam logic [c_YW-1:0]      c_HALF  = c_YW'(1) << (c_Y_FRAC - 1);
    localparam logic [c_YW-1:0]      c_K8    = c_YW'(5) << (ARG_FRAC + 2);
    localparam logic [c_YW-1:0]      c_K32   = c_YW'(27) << ARG_FRAC;
    localparam logic [c_YW-1:0]      c_T1    = c_YW'(1) << ARG_FRAC;
    localparam logic [c_YW-1:0]      c_T2375 = c_YW'(19) << (ARG_FRAC - 3);
    localparam logic [c_YW-1:0]      c_T5    = c_YW'(5) << ARG_FRAC;
    localparam logic [ACT_WIDTH:0]   c_M     = {1'b1, {ACT_WIDTH{1'b0}}};
    localparam logic [c_PW-1:0]      c_PBIAS = (c_PW'(c_ROUND_EN) << ACT_WIDTH) >> 1;
    localparam logic [ERR_WIDTH-1:0] c_ERR_MAX = {1'b0, {(ERR_WIDTH-1){1'b1}}};
    localparam logic [ERR_WIDTH-1:0] c_ERR_MIN = {1'b1, {(ERR_WIDTH-1){1'b0}}};

    logic                 r_act_valid;
    logic [ACT_WIDTH-1:0] r_act_data;
    logic                 r_prop_valid;
    logic [ERR_WIDTH-1:0] r_prop_data;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [ACT_WIDTH:0]   r_mem [DEPTH];

    logic                 w_full;
    logic                 w_empty;
    logic                 w_arg_fire;
    logic                 w_err_fire;
    logic                 w_push;

    // ------------------------------------------------------------------
    // Forward path
    // ------------------------------------------------------------------
    logic                 w_neg;
    logic [ARG_WIDTH:0]   w_arg_ext;
    logic [ARG_WIDTH:0]   w_abs;
    logic [c_YW-1:0]      w_abs_y;
    logic [c_YW-1:0]      w_y_mag;
    logic [c_YW-1:0]      w_y_log;
    logic [c_YW-1:0]      w_y_clip;
    logic [c_YW-1:0]      w_y;
    logic [c_SW-1:0]      w_scaled;
    logic [ACT_WIDTH-1:0] w_act;

    assign w_neg     = argument_data[ARG_WIDTH-1];
    assign w_arg_ext = {w_neg, argument_data};
    assign w_abs     = w_neg ? -w_arg_ext : w_arg_ext;
    assign w_abs_y   = c_YW'(w_abs);

    // w_abs_y read in y units is already |x|/32
    always_comb begin
        w_y_mag = c_ONE;
        if (w_abs_y < c_T1) begin
            w_y_mag = (w_abs_y << 3) + c_HALF;
        end else if (w_abs_y < c_T2375) begin
            w_y_mag = (w_abs_y << 2) + c_K8;
        end else if (w_abs_y < c_T5) begin
            w_y_mag = w_abs_y + c_K32;
        end
    end

    assign w_y_log = w_neg ? (c_ONE - w_y_mag) : w_y_mag;

    always_comb begin
        w_y_clip = '0;
        if (!w_neg) begin
            w_y_clip = (w_abs_y >= c_T1) ? c_ONE : (w_abs_y << 5);
        end
    end

    assign w_y = argument_mode ? w_y_clip : w_y_log;

    generate
        if (c_Y_FRAC >= ACT_WIDTH) begin : g_scale_down
            localparam int c_SH = c_Y_FRAC - ACT_WIDTH;
            localparam logic [c_YW-1:0] c_BIAS = (c_YW'(c_ROUND_EN) << c_SH) >> 1;
            assign w_scaled = c_SW'((w_y + c_BIAS) >> c_SH);
        end else begin : g_scale_up
            assign w_scaled = c_SW'(w_y) << (ACT_WIDTH - c_Y_FRAC);
        end
    endgenerate

    assign w_act = (|w_scaled[c_SW-1:ACT_WIDTH]) ? '1 : w_scaled[ACT_WIDTH-1:0];

    // ------------------------------------------------------------------
    // Backward path
    // ------------------------------------------------------------------
    logic [ACT_WIDTH:0]          w_head;
    logic [ACT_WIDTH-1:0]        w_a;
    logic                        w_a_mode;
    logic [c_AAW-1:0]            w_aa;
    logic [ACT_WIDTH:0]          w_d_log;
    logic [ACT_WIDTH:0]          w_d_clip;
    logic [ACT_WIDTH:0]          w_d;
    logic [c_PW-1:0]             w_err_ext;
    logic [c_PW-1:0]             w_prod_u;
    logic signed [c_PW-1:0]      w_prod_r;
    logic signed [c_PW-1:0]      w_shifted;
    logic [c_PW-ERR_WIDTH:0]     w_hi;
    logic [ERR_WIDTH-1:0]        w_prop;

    assign w_head   = r_mem[r_rd_ptr];
    assign w_a      = w_head[ACT_WIDTH:1];
    assign w_a_mode = w_head[0];

    assign w_aa     = c_AAW'(w_a) * c_AAW'(c_M - {1'b0, w_a});
    assign w_d_log  = (ACT_WIDTH+1)'(w_aa >> ACT_WIDTH);
    assign w_d_clip = (w_a != '0 && w_a != '1) ? c_M : '0;
    assign w_d      = w_a_mode ? w_d_clip : w_d_log;

    // Low c_PW bits of the product are the same whether signed or not
    assign w_err_ext = {{(c_PW-ERR_WIDTH){error_data[ERR_WIDTH-1]}}, error_data};
    assign w_prod_u  = w_err_ext * c_PW'(w_d);
    assign w_prod_r  = $signed(w_prod_u + c_PBIAS);
    assign w_shifted = w_prod_r >>> ACT_WIDTH;
    assign w_hi      = w_shifted[c_PW-1:ERR_WIDTH-1];

    always_comb begin
        w_prop = w_shifted[ERR_WIDTH-1:0];
        if (!((&w_hi) || !(|w_hi))) begin
            w_prop = w_shifted[c_PW-1] ? c_ERR_MIN : c_ERR_MAX;
        end
    end

    // ------------------------------------------------------------------
    // Handshakes and state
    // ------------------------------------------------------------------
    assign w_full     = (r_count == c_CNT_W'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign argument_ready = (!r_act_valid || activation_ready) && !(train && w_full);
    assign error_ready    = train && !w_empty && (!r_prop_valid || propagate_ready);
    assign w_arg_fire = argument_valid && argument_ready;
    assign w_err_fire = error_valid && error_ready;
    assign w_push     = w_arg_fire && train;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_act_valid  <= 1'b0;
            r_act_data   <= '0;
            r_prop_valid <= 1'b0;
            r_prop_data  <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
        end else begin
            if (w_arg_fire) begin
                r_act_valid <= 1'b1;
                r_act_data  <= w_act;
            end else if (activation_ready) begin
                r_act_valid <= 1'b0;
            end

            if (w_err_fire) begin
                r_prop_valid <= 1'b1;
                r_prop_data  <= w_prop;
            end else if (propagate_ready) begin
                r_prop_valid <= 1'b0;
            end

            if (!train) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                end
                if (w_err_fire) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
                case ({w_push, w_err_fire})
                    2'b10:   r_count <= r_count + c_CNT_W'(1);
                    2'b01:   r_count <= r_count - c_CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_act, argument_mode};
        end
    end

    assign activation_valid = r_act_valid;
    assign activation_data  = r_act_data;
    assign propagate_valid  = r_prop_valid;
    assign propagate_data   = r_prop_data;

endmodule
`default_nettype wire

// File: tb/tb_activation.sv
`default_nettype none
// ============================================================================
// Module   : tb_activation
// Brief    : Self-checking bench for activation: per-cycle model comparison
//            plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_activation;
    localparam int ARG_WIDTH = 16;
    localparam int ARG_FRAC  = 8;
    localparam int ACT_WIDTH = 8;
    localparam int ERR_WIDTH = 16;
    localparam int DEPTH     = 4;

    logic        clock;
    logic        reset;
    logic        train;
    logic        argument_valid;
    logic        argument_ready;
    logic [15:0] argument_data;
    logic        argument_mode;
    logic        activation_valid;
    logic        activation_ready;
    logic [7:0]  activation_data;
    logic        error_valid;
    logic        error_ready;
    logic [15:0] error_data;
    logic        propagate_valid;
    logic        propagate_ready;
    logic [15:0] propagate_data;

    int n_pass  = 0;
    int n_total = 0;

    activation #(
        .ARG_WIDTH(ARG_WIDTH), .ARG_FRAC(ARG_FRAC), .ACT_WIDTH(ACT_WIDTH),
        .ERR_WIDTH(ERR_WIDTH), .DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .train(train),
        .argument_valid(argument_valid), .argument_ready(argument_ready),
        .argument_data(argument_data), .argument_mode(argument_mode),
        .activation_valid(activation_valid), .activation_ready(activation_ready),
        .activation_data(activation_data),
        .error_valid(error_valid), .error_ready(error_ready), .error_data(error_data),
        .propagate_valid(propagate_valid), .propagate_ready(propagate_ready),
        .propagate_data(propagate_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Activation straight from the piecewise definition, in real arithmetic
    function automatic logic [7:0] model_act(input logic [15:0] x, input logic mode);
        int  xi;
        real xr, ax, y, s;
        xi = $signed(x);
        xr = $itor(xi) / 256.0;
        ax = (xr < 0.0) ? -xr : xr;
        if (mode) begin
            y = (xr < 0.0) ? 0.0 : ((xr > 1.0) ? 1.0 : xr);
        end else begin
            if (ax >= 5.0)        y = 1.0;
            else if (ax >= 2.375) y = ax / 32.0 + 0.84375;
            else if (ax >= 1.0)   y = ax / 8.0 + 0.625;
            else                  y = ax / 4.0 + 0.5;
            if (xr < 0.0) y = 1.0 - y;
        end
        s = y * 256.0;
`ifdef ACTIVATION_ROUND_EN
        s = s + 0.5;
`endif
        s = $floor(s);
        if (s > 255.0) s = 255.0;
        return 8'($rtoi(s));
    endfunction

    // Entry layout in the model queue: {activation[7:0], mode}
    function automatic logic [15:0] model_prop(input logic [15:0] err, input logic [8:0] ent);
        int  a, d, e, p;
        real r;
        a = int'(ent[8:1]);
        if (ent[0]) d = (a > 0 && a < 255) ? 256 : 0;
        else        d = (a * (256 - a)) / 256;
        e = $signed(err);
        r = $itor(e * d) / 256.0;
`ifdef ACTIVATION_ROUND_EN
        r = r + 0.5;
`endif
        p = $rtoi($floor(r));
        if (p > 32767)  p = 32767;
        if (p < -32768) p = -32768;
        return 16'(p);
    endfunction

    // ------------------------------------------------------------------
    // Cycle-level model and compare process
    // ------------------------------------------------------------------
    logic        m_av;
    logic        m_pv;
    logic [7:0]  m_ad;
    logic [15:0] m_pd;
    logic [8:0]  m_q [$];

    initial begin : mon
        logic       exp_ar;
        logic       exp_er;
        logic [8:0] ent;
        m_av = 1'b0; m_pv = 1'b0; m_ad = '0; m_pd = '0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                m_av = 1'b0; m_pv = 1'b0; m_ad = '0; m_pd = '0;
                m_q.delete();
            end
            exp_ar = (!m_av || activation_ready) && !(train && m_q.size() == DEPTH);
            exp_er = train && (m_q.size() != 0) && (!m_pv || propagate_ready);
            chk("mon_act_valid", activation_valid, m_av);
            chk("mon_act_data", activation_data, m_ad);
            chk("mon_prop_valid", propagate_valid, m_pv);
            chk("mon_prop_data", propagate_data, m_pd);
            chk("mon_arg_ready", argument_ready, exp_ar);
            chk("mon_err_ready", error_ready, exp_er);
            if (reset) begin
                if (error_valid && exp_er) begin
                    ent  = m_q.pop_front();
                    m_pd = model_prop(error_data, ent);
                    m_pv = 1'b1;
                end else if (propagate_ready) begin
                    m_pv = 1'b0;
                end
                if (argument_valid && exp_ar) begin
                    m_ad = model_act(argument_data, argument_mode);
                    m_av = 1'b1;
                    if (train) m_q.push_back({m_ad, argument_mode});
                end else if (activation_ready) begin
                    m_av = 1'b0;
                end
                if (!train) m_q.delete();
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus (tasks start and end at posedge + 2)
    // ------------------------------------------------------------------
    task automatic send_arg(input logic [15:0] x, input logic m);
        bit ok;
        ok = 1'b0;
        argument_valid = 1'b1; argument_data = x; argument_mode = m;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clock);
            if (argument_ready) ok = 1'b1;
        end
        @(posedge clock); #2;
        argument_valid = 1'b0;
        if (!ok) chk("timeout_arg", 0, 1);
    endtask

    task automatic send_err(input logic [15:0] e);
        bit ok;
        ok = 1'b0;
        error_valid = 1'b1; error_data = e;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clock);
            if (error_ready) ok = 1'b1;
        end
        @(posedge clock); #2;
        error_valid = 1'b0;
        if (!ok) chk("timeout_err", 0, 1);
    endtask

    task automatic expect_act(input string name, input logic [7:0] exp);
        @(negedge clock);
        chk({name, "_valid"}, activation_valid, 1);
        chk(name, activation_data, exp);
        @(posedge clock); #2;
    endtask

    task automatic expect_prop(input string name, input logic [15:0] exp);
        @(negedge clock);
        chk({name, "_valid"}, propagate_valid, 1);
        chk(name, propagate_data, exp);
        @(posedge clock); #2;
    endtask

    logic [15:0] sweep_x [10] = '{16'h0260, 16'h025F, 16'h0500, 16'h04FF, 16'h8000,
                                  16'h00FF, 16'h0100, 16'hFFFF, 16'h8000, 16'hFDA0};
    logic        sweep_m [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin : drv
        reset = 1'b1; train = 1'b0;
        argument_valid = 1'b0; argument_data = '0; argument_mode = 1'b0;
        activation_ready = 1'b1; error_valid = 1'b0; error_data = '0;
        propagate_ready = 1'b1;

        chk("model_act_neg1", model_act(16'hFF00, 1'b0), 8'h40);
        chk("model_act_zero", model_act(16'h0000, 1'b0), 8'h80);
        chk("model_prop_s3", model_prop(16'h0100, {8'h40, 1'b0}), 16'h0030);

        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_act_valid", activation_valid, 0);
        chk("rst_act_data", activation_data, 0);
        chk("rst_prop_valid", propagate_valid, 0);
        chk("rst_prop_data", propagate_data, 0);
        chk("rst_arg_ready", argument_ready, 1);
        chk("rst_err_ready", error_ready, 0);
        @(posedge clock); #2 reset = 1'b1;

        // Scenario 1: train off
        send_arg(16'h0000, 1'b0);
        expect_act("s1_act", 8'h80);
        error_valid = 1'b1; error_data = 16'h0100;
        repeat (3) begin
            @(negedge clock);
            chk("s1_err_ready", error_ready, 0);
        end
        @(posedge clock); #2 error_valid = 1'b0;

        // Scenarios 2-4: train on, forward then backward
        train = 1'b1;
        send_arg(16'h0600, 1'b0); expect_act("s2_act", 8'hFF);
        send_err(16'hFE00);       expect_prop("s2_prop", 16'h0000);
        send_arg(16'hFF00, 1'b0); expect_act("s3_act", 8'h40);
        send_err(16'h0100);       expect_prop("s3_prop", 16'h0030);
        send_arg(16'h0040, 1'b1); expect_act("s4_act0", 8'h40);
        send_arg(16'hFF00, 1'b1); expect_act("s4_act1", 8'h00);
        send_err(16'h0300);       expect_prop("s4_prop0", 16'h0300);
        send_err(16'h0300);       expect_prop("s4_prop1", 16'h0000);

        // Scenario 5: fill the FIFO
        send_arg(16'hFD00, 1'b0); expect_act("s5_act0", 8'h10);
        send_arg(16'h0180, 1'b0); expect_act("s5_act1", 8'hD0);
        send_arg(16'h0080, 1'b1); expect_act("s5_act2", 8'h80);
        send_arg(16'h7FFF, 1'b1); expect_act("s5_act3", 8'hFF);
        argument_valid = 1'b1; argument_data = 16'h0000; argument_mode = 1'b0;
        @(negedge clock);
        chk("s5_full_ready", argument_ready, 0);
        @(posedge clock); #2;
        error_valid = 1'b1; error_data = 16'h0100;
        @(negedge clock);
        chk("s5_ready_during_pop", argument_ready, 0);
        chk("s5_err_ready", error_ready, 1);
        @(posedge clock); #2 error_valid = 1'b0;
        @(negedge clock);
        chk("s5_ready_after_pop", argument_ready, 1);
        chk("s5_prop_first", propagate_data, 16'h000F);
        @(posedge clock); #2 argument_valid = 1'b0;
        send_err(16'hFF00); expect_prop("s5_prop_neg", 16'hFFD9);

        // Simultaneous push and pop keeps the count at 3
        argument_valid = 1'b1; argument_data = 16'hFE80; argument_mode = 1'b0;
        error_valid = 1'b1; error_data = 16'h0200;
        @(negedge clock);
        chk("pp_arg_ready", argument_ready, 1);
        chk("pp_err_ready", error_ready, 1);
        @(posedge clock); #2;
        argument_valid = 1'b0; error_valid = 1'b0;
        @(negedge clock);
        chk("pp_act", activation_data, 8'h30);
        chk("pp_prop", propagate_data, 16'h0200);
        chk("pp_not_full", argument_ready, 1);
        @(posedge clock); #2;

        // Scenario 6: reset with two stored entries and a stalled result
        send_err(16'h0100); expect_prop("s6_pop0", 16'h0000);
        send_err(16'h0400); expect_prop("s6_pop1", 16'h0100);
        activation_ready = 1'b0;
        send_arg(16'h0000, 1'b1);
        @(negedge clock);
        chk("s6_stall_valid", activation_valid, 1);
        chk("s6_stall_ready", argument_ready, 0);
        chk("s6_err_ready_pre", error_ready, 1);
        @(posedge clock); #2 reset = 1'b0;
        #1;
        chk("s6_act_valid_now", activation_valid, 0);
        chk("s6_err_ready_now", error_ready, 0);
        chk("s6_arg_ready_now", argument_ready, 1);
        @(posedge clock); #2;
        reset = 1'b1; activation_ready = 1'b1;
        @(negedge clock);
        chk("s6_empty_after", error_ready, 0);
        @(posedge clock); #2;

        // Dropping train for one edge clears the FIFO
        send_arg(16'h0100, 1'b0); expect_act("tr_act", 8'hC0);
        train = 1'b0;
        @(posedge clock); #2 train = 1'b1;
        @(negedge clock);
        chk("tr_cleared", error_ready, 0);
        @(posedge clock); #2;

        // Error extremes against stored activations
        send_arg(16'h0033, 1'b0);
        send_arg(16'hFE00, 1'b0);
        send_arg(16'h0020, 1'b1);
        send_err(16'h8000);
        send_err(16'h7FFF);
        send_err(16'hFF37);
        repeat (2) @(posedge clock);
        #2;

        // Threshold sweep with train off
        train = 1'b0;
        for (int i = 0; i < 10; i++) send_arg(sweep_x[i], sweep_m[i]);

        repeat (3) @(posedge clock);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
